// File: rtl/lsu_ctrl.sv
// Load/store unit controller: captures one execute-stage memory op, runs a
// req/gnt/rvalid handshake on the data bus, and formats store data and load writeback.
module lsu_ctrl #(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,

    input  logic        valid_in,
    input  logic        mem_rd_in,
    input  logic        mem_wr_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [4:0]  rd_addr_in,

    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_in,
    input  logic        dmem_rvalid_in,
    input  logic [31:0] dmem_rdata_in,

    output logic        stall_o,

    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic [31:0] wb_data_o,

    output logic        misalign_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } state_e;

    localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [4:0]  rd_q;

    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic        misalign_q;
    logic        err_q;

    logic        is_op;
    logic        aligned;
    logic        accept;
    logic        bad_op;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] rdata_shifted;
    logic [31:0] load_val;
    logic        rsp_ok;
    logic        timeout;

    // Operand decode for the op presented in IDLE
    always_comb begin
        is_op = mem_rd_in | mem_wr_in;
        case (load_size_in)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr_in[0];
            2'b10:   aligned = (addr_in[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        accept = (state_q == StIdle) & valid_in & is_op & aligned;
        bad_op = (state_q == StIdle) & valid_in & is_op & ~aligned;
    end

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = wdata_in;
        case (load_size_in)
            2'b00: begin
                be_new    = 4'b0001 << addr_in[1:0];
                wdata_new = {4{wdata_in[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << addr_in[1:0];
                wdata_new = {2{wdata_in[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = wdata_in;
            end
        endcase
    end

    // Align the addressed lane down to bit 0, then extend to 32 bits
    always_comb begin
        rdata_shifted = dmem_rdata_in >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   load_val = {{24{~unsigned_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'b01:   load_val = {{16{~unsigned_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_val = rdata_shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rsp_ok     = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (dmem_gnt_in) begin
                    state_d    = we_q ? StDone : StWait;
                    wait_cnt_d = 8'd0;
                end
            end
            StWait: begin
                if (dmem_rvalid_in) begin
                    rsp_ok  = 1'b1;
                    state_d = StDone;
                end else if (wait_cnt_q == WaitLast) begin
                    timeout = 1'b1;
                    state_d = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Request fields are frozen at acceptance so the bus sees stable values until grant
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            addr_q     <= 32'd0;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'd0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            rd_q       <= 5'd0;
        end else if (accept) begin
            addr_q     <= addr_in;
            we_q       <= mem_wr_in;
            be_q       <= be_new;
            wdata_q    <= wdata_new;
            size_q     <= load_size_in;
            unsigned_q <= load_unsigned_in;
            rd_q       <= rd_addr_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wb_valid_q <= rsp_ok & (rd_q != 5'd0);
            misalign_q <= bad_op;
            err_q      <= timeout;
            if (rsp_ok) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= load_val;
            end
        end
    end

    assign dmem_req_o   = (state_q == StReq);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;

    assign stall_o      = (state_q == StReq) | (state_q == StWait) | accept;

    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_addr_o = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign misalign_o   = misalign_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vectors plus randomized ops compared
// against a transaction-level model of byte lanes, alignment and latency.
module tb_lsu_ctrl;

    localparam int unsigned WAIT_MAX = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in, mem_rd_in, mem_wr_in, load_unsigned_in;
    logic [31:0] addr_in, wdata_in;
    logic [1:0]  load_size_in;
    logic [4:0]  rd_addr_in;
    logic        dmem_req_o, dmem_we_o, dmem_gnt_in, dmem_rvalid_in;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_in;
    logic [3:0]  dmem_be_o;
    logic        stall_o, wb_valid_o, misalign_o, err_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_data_o;

    always #5 clk_in = ~clk_in;

    lsu_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .valid_in         (valid_in),
        .mem_rd_in        (mem_rd_in),
        .mem_wr_in        (mem_wr_in),
        .addr_in          (addr_in),
        .wdata_in         (wdata_in),
        .load_size_in     (load_size_in),
        .load_unsigned_in (load_unsigned_in),
        .rd_addr_in       (rd_addr_in),
        .dmem_req_o       (dmem_req_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_be_o        (dmem_be_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_gnt_in      (dmem_gnt_in),
        .dmem_rvalid_in   (dmem_rvalid_in),
        .dmem_rdata_in    (dmem_rdata_in),
        .stall_o          (stall_o),
        .wb_valid_o       (wb_valid_o),
        .wb_rd_addr_o     (wb_rd_addr_o),
        .wb_data_o        (wb_data_o),
        .misalign_o       (misalign_o),
        .err_o            (err_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_wb_data;
    logic [4:0]  exp_wb_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_legal(input bit rd, input bit wr, input logic [31:0] a,
                                       input logic [1:0] sz);
        if (!(rd || wr) || sz == 2'd3) return 1'b0;
        if (sz == 2'd1) return (a % 2) == 0;
        if (sz == 2'd2) return (a % 4) == 0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
        int n   = 1 << sz;
        int off = int'(a % 4);
        return 4'(((1 << n) - 1) << off);
    endfunction

    // Every bus byte lane carries the store byte that maps onto it modulo the access size
    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] r;
        int n = 1 << sz;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] a,
                                               input logic [1:0] sz, input bit uns);
        int n   = 1 << sz;
        int off = int'(a % 4);
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        logic [63:0] v    = ({32'd0, rdata} >> (8 * off)) & mask;
        if (!uns && n < 4 && v[8*n-1]) v = v - mask - 64'd1;
        return v[31:0];
    endfunction

    task automatic scramble(input bit keep_valid_low);
        valid_in         = keep_valid_low ? 1'b0 : 1'($urandom);
        mem_rd_in        = 1'($urandom);
        mem_wr_in        = 1'($urandom);
        addr_in          = $urandom;
        wdata_in         = $urandom;
        load_size_in     = 2'($urandom);
        load_unsigned_in = 1'($urandom);
        rd_addr_in       = 5'($urandom);
    endtask

    // Run one op through IDLE/REQ/WAIT/DONE; rv_dly >= WAIT_MAX means rvalid never comes
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input bit uns, input logic [4:0] rda,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        bit legal   = model_legal(rd, wr, a, sz);
        bit timeout = !wr && (rv_dly >= int'(WAIT_MAX));
        int stalls  = 0;
        int exp_stalls;

        valid_in = 1'b1; mem_rd_in = rd; mem_wr_in = wr; addr_in = a; wdata_in = wd;
        load_size_in = sz; load_unsigned_in = uns; rd_addr_in = rda;
        dmem_gnt_in = 1'b0; dmem_rvalid_in = 1'b0;
        @(negedge clk_in);
        check("idle_stall", stall_o, legal);
        check("idle_req", dmem_req_o, 0);
        stalls += int'(stall_o);
        @(posedge clk_in); #1;

        if (!legal) begin
            scramble(1'b1);
            @(negedge clk_in);
            check("misalign_pulse", misalign_o, rd | wr);
            check("bad_stall", stall_o, 0);
            check("bad_req", dmem_req_o, 0);
            @(posedge clk_in); #1;
            @(negedge clk_in);
            check("misalign_clear", misalign_o, 0);
            check("bad_req2", dmem_req_o, 0);
            @(posedge clk_in); #1;
            return;
        end

        scramble(1'b0);
        for (int i = 0; i <= gnt_dly; i++) begin
            dmem_gnt_in = (i == gnt_dly);
            @(negedge clk_in);
            check("req_req", dmem_req_o, 1);
            check("req_stall", stall_o, 1);
            check("req_we", dmem_we_o, wr);
            check("req_addr", dmem_addr_o, a & 32'hFFFF_FFFC);
            check("req_be", dmem_be_o, model_be(a, sz));
            if (wr) check("req_wdata", dmem_wdata_o, model_wdata(wd, sz));
            stalls += int'(stall_o);
            @(posedge clk_in); #1;
            scramble(1'b0);
        end
        dmem_gnt_in = 1'b0;

        if (!wr) begin
            for (int j = 0; j < int'(WAIT_MAX); j++) begin
                dmem_rvalid_in = (j == rv_dly);
                dmem_rdata_in  = (j == rv_dly) ? rdata : $urandom;
                @(negedge clk_in);
                check("wait_stall", stall_o, 1);
                check("wait_req", dmem_req_o, 0);
                check("wait_err", err_o, 0);
                stalls += int'(stall_o);
                @(posedge clk_in); #1;
                if (j == rv_dly) break;
            end
            dmem_rvalid_in = 1'b0;
        end

        // A legal op offered during DONE must not be taken
        valid_in = 1'b1; mem_rd_in = 1'b1; mem_wr_in = 1'b0; addr_in = 32'h200;
        load_size_in = 2'd2; rd_addr_in = 5'd7;
        @(negedge clk_in);
        if (!wr && !timeout) begin
            exp_wb_data = model_load(rdata, a, sz, uns);
            exp_wb_rd   = rda;
        end
        check("done_stall", stall_o, 0);
        check("done_req", dmem_req_o, 0);
        check("done_err", err_o, timeout);
        check("done_wb_valid", wb_valid_o, !wr && !timeout && rda != 5'd0);
        check("done_wb_data", wb_data_o, exp_wb_data);
        check("done_wb_rd", wb_rd_addr_o, exp_wb_rd);
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        @(negedge clk_in);
        check("after_req", dmem_req_o, 0);
        check("after_stall", stall_o, 0);
        check("after_wb_valid", wb_valid_o, 0);
        check("after_err", err_o, 0);
        check("after_wb_data", wb_data_o, exp_wb_data);
        exp_stalls = 1 + (gnt_dly + 1) + (wr ? 0 : (timeout ? int'(WAIT_MAX) : rv_dly + 1));
        check("stall_cycles", stalls, exp_stalls);
        @(posedge clk_in); #1;
    endtask

    initial begin
        bit          rd, wr, uns;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [4:0]  rda;
        int          gd, rv;

        rst_in = 1'b1;
        valid_in = 1'b0; mem_rd_in = 1'b0; mem_wr_in = 1'b0; addr_in = 32'd0; wdata_in = 32'd0;
        load_size_in = 2'd0; load_unsigned_in = 1'b0; rd_addr_in = 5'd0;
        dmem_gnt_in = 1'b0; dmem_rvalid_in = 1'b0; dmem_rdata_in = 32'd0;
        exp_wb_data = 32'd0; exp_wb_rd = 5'd0;
        #2;
        check("rst_req", dmem_req_o, 0);
        check("rst_be", dmem_be_o, 0);
        check("rst_addr", dmem_addr_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_wb_data", wb_data_o, 0);
        check("rst_misalign", misalign_o, 0);
        check("rst_err", err_o, 0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // Directed vectors
        do_op(1, 0, 32'h100, 32'h0, 2'd2, 0, 5'd3, 0, 0, 32'hDEADBEEF);
        check("lw_const", wb_data_o, 32'hDEADBEEF);
        do_op(1, 0, 32'h103, 32'h0, 2'd0, 0, 5'd4, 0, 0, 32'h80112233);
        check("lb_signed_const", wb_data_o, 32'hFFFFFF80);
        do_op(1, 0, 32'h103, 32'h0, 2'd0, 1, 5'd4, 0, 0, 32'h80112233);
        check("lb_unsigned_const", wb_data_o, 32'h00000080);
        do_op(0, 1, 32'h102, 32'h0000ABCD, 2'd1, 0, 5'd9, 1, 0, 32'h0);
        check("sh_wdata_const", dmem_wdata_o, 32'hABCDABCD);
        check("sh_be_const", dmem_be_o, 4'b1100);
        do_op(1, 0, 32'h101, 32'h0, 2'd2, 0, 5'd5, 0, 0, 32'h0);
        do_op(1, 0, 32'h104, 32'h0, 2'd2, 0, 5'd6, 0, WAIT_MAX, 32'h0);
        do_op(1, 0, 32'h108, 32'h0, 2'd1, 0, 5'd0, 2, WAIT_MAX - 1, 32'h0000F00D);
        do_op(1, 1, 32'h10C, 32'h11223344, 2'd2, 0, 5'd8, 0, 0, 32'h0);
        do_op(1, 0, 32'h110, 32'h0, 2'd3, 0, 5'd8, 0, 0, 32'h0);

        // Reset while waiting for rvalid, then a stray rvalid
        valid_in = 1'b1; mem_rd_in = 1'b1; mem_wr_in = 1'b0; addr_in = 32'h300;
        load_size_in = 2'd2; rd_addr_in = 5'd5;
        @(posedge clk_in); #1;
        valid_in = 1'b0; dmem_gnt_in = 1'b1;
        @(posedge clk_in); #1;
        dmem_gnt_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b1; #1;
        check("midrst_req", dmem_req_o, 0);
        check("midrst_stall", stall_o, 0);
        check("midrst_be", dmem_be_o, 0);
        check("midrst_wb_data", wb_data_o, 0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        exp_wb_data = 32'd0; exp_wb_rd = 5'd0;
        dmem_rvalid_in = 1'b1; dmem_rdata_in = 32'h12345678;
        @(negedge clk_in);
        check("late_stall", stall_o, 0);
        check("late_req", dmem_req_o, 0);
        @(posedge clk_in); #1;
        dmem_rvalid_in = 1'b0;
        @(negedge clk_in);
        check("late_wb_valid", wb_valid_o, 0);
        check("late_wb_data", wb_data_o, 0);
        @(posedge clk_in); #1;

        // Randomized ops
        for (int k = 0; k < 300; k++) begin
            sz  = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            a   = $urandom;
            if ($urandom % 4 != 0) a = a & ~((32'd1 << sz) - 32'd1);
            rd  = 1'($urandom);
            wr  = 1'($urandom);
            uns = 1'($urandom);
            rda = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
            gd  = int'($urandom % 4);
            case ($urandom % 12)
                0:       rv = int'(WAIT_MAX);
                1:       rv = int'(WAIT_MAX) - 1;
                default: rv = int'($urandom % 5);
            endcase
            do_op(rd, wr, a, $urandom, sz, uns, rda, gd, rv, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
